// File: rtl/cpu_ctrl_pkg.sv
// Shared definitions for the hard-wired control sequencer: state encoding,
// opcode class, opcode map and instruction-register field positions.
package cpu_ctrl_pkg;

    typedef enum logic [3:0] {
        RST, T0, T1, T2, T3, T4, T5, T6, HALT, STEPWAIT
    } state_t;

    typedef enum logic [2:0] {
        CLS_ALU, CLS_MULDIV, CLS_UNARY, CLS_NOP, CLS_HALT, CLS_ILLEGAL
    } op_class_t;

    localparam int OP_MSB = 31;
    localparam int OP_LSB = 27;
    localparam int RA_MSB = 26;
    localparam int RA_LSB = 23;
    localparam int RB_MSB = 22;
    localparam int RB_LSB = 19;
    localparam int RC_MSB = 18;
    localparam int RC_LSB = 15;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHL  = 5'b01011;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier: maps the 5-bit opcode field onto the
// execution path it takes through the sequencer.
module opcode_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [4:0] opcode,
    output op_class_t  op_class
);

    always_comb begin
        unique case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL: op_class = CLS_ALU;
            OP_MUL, OP_DIV:                  op_class = CLS_MULDIV;
            OP_NEG, OP_NOT:                  op_class = CLS_UNARY;
            OP_NOP:                          op_class = CLS_NOP;
            OP_HALT:                         op_class = CLS_HALT;
            default:                         op_class = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Moore fetch/execute sequencer for register-register instructions.
// Optional single-step mode is enabled by defining STEP_MODE_EN.
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int OPW  = 5,
    parameter int CNTW = 16
) (
    input  logic            Clock,
    input  logic            Reset_n,
    input  logic [31:0]     IR,
    input  logic            MemReady,
    input  logic            Stop,
    input  logic            Step,
    output logic            PCout,
    output logic            Zlowout,
    output logic            ZHighout,
    output logic            MDRout,
    output logic            MARin,
    output logic            PCin,
    output logic            MDRin,
    output logic            IRin,
    output logic            Yin,
    output logic            Zin,
    output logic            LOin,
    output logic            HIin,
    output logic            IncPC,
    output logic            Read,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic [OPW-1:0]  operation,
    output logic            Run,
    output logic            IllegalOp,
    output logic [CNTW-1:0] InstrCount
);

    state_t          state_q, state_d;
    op_class_t       ir_class, class_q;
    logic [OPW-1:0]  op_q;
    logic            stop_q;
    logic            illegal_q;
    logic [CNTW-1:0] count_q;
    logic            end_of_instr;
    state_t          resume_state;
    logic            step_go;

    // Register selects come from IR fields downstream; only the opcode is used here.
    logic unused_ir_fields;
    assign unused_ir_fields = ^IR[RA_MSB:0];

    opcode_decoder u_decoder (
        .opcode   (IR[OP_MSB:OP_LSB]),
        .op_class (ir_class)
    );

`ifdef STEP_MODE_EN
    logic [2:0] step_sync_q;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) step_sync_q <= '0;
        else          step_sync_q <= {step_sync_q[1:0], Step};
    end

    assign step_go      = step_sync_q[1] & ~step_sync_q[2];
    assign resume_state = STEPWAIT;
`else
    logic unused_step;
    assign unused_step  = Step;
    assign step_go      = 1'b0;
    assign resume_state = T0;
`endif

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        state_d      = state_q;
        end_of_instr = 1'b0;
        case (state_q)
            RST: state_d = T0;
            T0:  state_d = T1;
            T1:  if (MemReady) state_d = T2;
            T2: begin
                if (ir_class inside {CLS_ALU, CLS_MULDIV, CLS_UNARY}) state_d = T3;
                else end_of_instr = 1'b1;
            end
            T3:  state_d = T4;
            T4: begin
                if (class_q == CLS_UNARY) end_of_instr = 1'b1;
                else state_d = T5;
            end
            T5: begin
                if (class_q == CLS_MULDIV) state_d = T6;
                else end_of_instr = 1'b1;
            end
            T6:  end_of_instr = 1'b1;
            HALT: state_d = HALT;
            STEPWAIT: begin
                if (stop_q)       state_d = HALT;
                else if (step_go) state_d = T0;
            end
            default: state_d = RST;
        endcase
        if (end_of_instr)
            state_d = (stop_q || (state_q == T2 && ir_class == CLS_HALT)) ? HALT : resume_state;
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
        if (!Reset_n) begin
            state_q   <= RST;
            op_q      <= '0;
            class_q   <= CLS_NOP;
            stop_q    <= 1'b0;
            illegal_q <= 1'b0;
            count_q   <= '0;
        end else begin
            state_q   <= state_d;
            illegal_q <= (state_q == T2) && (ir_class == CLS_ILLEGAL);
            if (Stop) stop_q <= 1'b1;
            if (state_q == T2) begin
                op_q    <= OPW'(IR[OP_MSB:OP_LSB]);
                class_q <= ir_class;
            end
            if (end_of_instr) count_q <= count_q + CNTW'(1);
        end
    end

    always_comb begin
        {PCout, Zlowout, ZHighout, MDRout, MARin, PCin, MDRin, IRin} = '0;
        {Yin, Zin, LOin, HIin, IncPC, Read}                         = '0;
        {Gra, Grb, Grc, Rin, Rout}                                   = '0;
        operation = '0;
        case (state_q)
            T0: {PCout, MARin, IncPC, Zin} = '1;
            T1: {Zlowout, PCin, Read, MDRin} = '1;
            T2: {MDRout, IRin} = '1;
            T3: begin
                {Grb, Rout} = '1;
                if (class_q == CLS_UNARY) begin
                    Zin       = 1'b1;
                    operation = op_q;
                end else begin
                    Yin = 1'b1;
                end
            end
            T4: begin
                if (class_q == CLS_UNARY) begin
                    {Zlowout, Gra, Rin} = '1;
                end else begin
                    {Grc, Rout, Zin} = '1;
                    operation = op_q;
                end
            end
            T5: begin
                Zlowout = 1'b1;
                if (class_q == CLS_MULDIV) LOin = 1'b1;
                else {Gra, Rin} = '1;
            end
            T6: {ZHighout, HIin} = '1;
            default: ;
        endcase
    end

    assign Run        = (state_q != RST) && (state_q != HALT);
    assign IllegalOp  = illegal_q;
    assign InstrCount = count_q;

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Hard-wired control unit directly upstream of the datapath.
- Replaces the hand-driven T0..T5 control strobes with a Moore FSM that runs fetch and execute for register-register ALU instructions.
- Decodes IR fields into operation and register-select strobes.
- Handles a memory-ready stall in fetch, an external stop request, and halt.

Parameters:
- OPW, 5, opcode / operation width.
- CNTW, 16, retired-instruction counter width.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- IR  in  32  instruction register contents from the datapath.
- MemReady  in  1  memory read data valid; stalls T1 while low.
- Stop  in  1  request to halt after the current instruction.
- Step  in  1  single-step advance pulse; used only with STEP_MODE_EN.
- PCout, Zlowout, ZHighout, MDRout  out  1 each  bus drive strobes.
- MARin, PCin, MDRin, IRin, Yin, Zin, LOin, HIin  out  1 each  register load strobes.
- IncPC, Read  out  1 each  ALU PC-increment and memory read.
- Gra, Grb, Grc, Rin, Rout  out  1 each  register-file select and enable, decoded downstream from IR[26:23], IR[22:19] and IR[18:15].
- operation  out  OPW  ALU function code.
- Run  out  1  high while executing; low in halt.
- IllegalOp  out  1  one-cycle pulse on an undefined opcode.
- InstrCount  out  CNTW  retired-instruction count.

Behaviour:
- Reset:
  - Asynchronous on Reset_n low.
  - State goes to RST. All strobes 0, operation 0, Run 0, IllegalOp 0, InstrCount 0.
  - Reset mid-instruction aborts immediately. No partial strobes persist.
- Outputs:
  - Moore outputs, decoded from the registered state plus registered opcode.
  - opcode is captured from IR[31:27] on the T2→T3 edge.
- States and strobes:
  - RST: all strobes 0. Next: T0. Run goes 1 from T0 onward.
  - T0: PCout, MARin, IncPC, Zin. Next: T1.
  - T1: Zlowout, PCin, Read, MDRin. All held while MemReady=0. Leave to T2 on the first edge where MemReady=1.
  - T2: MDRout, IRin. Next: decoded from IR[31:27] at this edge.
  - T3: Grb, Rout, Yin.
    - For neg/not instead: Grb, Rout, Zin, operation=opcode.
  - T4: Grc, Rout, Zin, operation=opcode.
    - For neg/not instead: Zlowout, Gra, Rin (end of instruction).
  - T5: Zlowout plus either Gra+Rin (ALU ops) or LOin (mul/div).
  - T6: mul/div only. ZHighout, HIin.
  - HALT: Run=0, all strobes 0. Exit only by reset.
- Opcodes:
  - ALU: add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011. Path: T2→T3→T4→T5→T0.
  - mul 01111, div 10000: T2→…→T6→T0.
  - neg 10001, not 10010: T2→T3→T4→T0.
  - nop 11010: T2→T0.
  - halt 11011: T2→HALT.
  - Any other opcode: treated as nop, IllegalOp=1 during the T2→T0 transition cycle.
- operation is 0 outside the states listed above.
- End of instruction:
  - The last execute state, or T2 for nop/illegal.
  - InstrCount increments, wrapping to 0 after all-ones. Halt counts as retired.
- Stop:
  - Latched whenever high. Cleared only by reset.
  - At end of instruction with Stop pending, next state is HALT instead of T0.
  - Stop asserted during T0..T2 still lets the current instruction complete.
- Simultaneous events:
  - Stop pending and halt opcode: HALT.
  - MemReady already high on entry to T1: single-cycle T1.

Optional Feature:
- STEP_MODE_EN defined:
  - At each end of instruction the FSM enters STEPWAIT (all strobes 0, Run=1).
  - T0 follows the cycle after a rising edge of Step, synchronised internally with 2 flops.
  - Stop pending in STEPWAIT goes to HALT.
- Undefined: Step is ignored and no STEPWAIT state exists.

Decomposition:
- Package cpu_ctrl_pkg:
  - state enum (RST, T0..T6, HALT, STEPWAIT);
  - opcode localparams listed above;
  - IR field bit positions.
- One sub-module: opcode_decoder. Combinational; maps opcode to class (ALU, MULDIV, UNARY, NOP, HALT, ILLEGAL).
- FSM and counter live in control_sequencer.

Test Plan:
- IR=0x2A2B8000, MemReady=1:
  - T3 asserts Grb,Rout,Yin.
  - T4 asserts Grc,Rout,Zin with operation=5'b00101.
  - T5 asserts Zlowout,Gra,Rin.
  - T0 follows; InstrCount=1.
- MemReady low for 3 cycles in T1 → T1 strobes held 4 cycles total, then T2. IncPC seen only in T0.
- IR opcode 01111 (mul) → T5 asserts Zlowout+LOin, T6 asserts ZHighout+HIin, then T0.
- IR opcode 11111 → IllegalOp pulses 1 cycle, no T3. Next instruction fetched; InstrCount increments.
- Stop pulsed during T3 of an add → T5 completes, then HALT with Run=0. Further clocks change nothing.
- Reset_n dropped mid-T4 → strobes 0 and InstrCount 0 asynchronously. After release: RST, then T0.
